// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: captures one padded 512-bit block and streams the
// 64 round pairs (W_j, W'_j) through a 16-word sliding window.
module sm3_msg_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [0:511] blk,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_j,
  output logic [31:0]  wp_j,
  output logic [5:0]   round,
  output logic         last
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  round_q, round_d;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // Next-state: block capture in IDLE, window shift and expansion per transfer in RUN
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          for (int unsigned i = 0; i < 16; i++) begin
            win_d[i] = blk[32*i +: 32];
          end
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          for (int unsigned i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = p1(win_q[0] ^ win_q[7] ^ rotl(win_q[13], 15))
                      ^ rotl(win_q[3], 7) ^ win_q[10];
          round_d   = round_q + 6'd1;
          if (round_q == 6'd63) begin
            round_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round counter and window registers; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      win_q   <= win_d;
    end
  end

  assign blk_ready = (state_q == IDLE);
  assign w_valid   = (state_q == RUN);
  assign w_j       = win_q[0];
  assign wp_j      = win_q[0] ^ win_q[4];
  assign round     = round_q;
  assign last      = (state_q == RUN) && (round_q == 6'd63);

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Self-checking bench for sm3_msg_expand against a flat 68-word SM3 expansion model.
module tb_sm3_msg_expand;

  logic         clk;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [0:511] blk;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_j;
  logic [31:0]  wp_j;
  logic [5:0]   round;
  logic         last;

  sm3_msg_expand dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk       (blk),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_j       (w_j),
    .wp_j      (wp_j),
    .round     (round),
    .last      (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int unsigned LIMIT = 2000;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned last_cyc;
  logic [31:0] blkw   [16];
  logic [31:0] mw     [68];
  logic [31:0] obs_w  [64];
  logic [31:0] obs_wp [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int unsigned n);
    logic [63:0] d;
    d = {x, x} >> (32 - n);
    return d[31:0];
  endfunction

  function automatic logic [31:0] mp1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  task automatic build_model();
    for (int j = 0; j < 16; j++) mw[j] = blkw[j];
    for (int j = 16; j < 68; j++)
      mw[j] = mp1(mw[j-16] ^ mw[j-9] ^ rl(mw[j-3], 15)) ^ rl(mw[j-13], 7) ^ mw[j-6];
  endtask

  // Offer blkw, then drain rounds until stop_at (64 = whole block)
  task automatic run_block(input int unsigned duty, input bit keep_valid,
                           input int unsigned stop_at);
    int unsigned j;
    int unsigned cyc;
    build_model();
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = blkw[i];
    blk_valid = 1'b1;
    w_ready   = 1'($urandom_range(1));
    @(posedge clk); #1;
    chk("accept_w_valid", 32'(w_valid), 32'd1);
    chk("accept_blk_ready", 32'(blk_ready), 32'd0);
    if (!keep_valid) blk_valid = 1'b0;
    j = 0;
    cyc = 0;
    while (j < stop_at && cyc <= LIMIT) begin
      chk("run_w_valid", 32'(w_valid), 32'd1);
      chk("run_blk_ready", 32'(blk_ready), 32'd0);
      chk("round", 32'(round), j);
      chk("w_j", w_j, mw[j]);
      chk("wp_j", wp_j, mw[j] ^ mw[j+4]);
      chk("last", 32'(last), 32'(j == 63));
      w_ready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      if (keep_valid)
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
      if (w_ready) begin
        obs_w[j]  = w_j;
        obs_wp[j] = wp_j;
      end
      @(posedge clk); #1;
      cyc++;
      if (w_ready) j++;
    end
    if (j < stop_at) chk("cycle_budget", cyc, LIMIT);
    last_cyc = cyc;
    if (stop_at == 64) begin
      chk("done_blk_ready", 32'(blk_ready), 32'd1);
      chk("done_w_valid", 32'(w_valid), 32'd0);
      chk("done_last", 32'(last), 32'd0);
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blkw[i] = 32'h0;
    blkw[0]  = 32'h61626380;
    blkw[15] = 32'h00000018;
  endtask

  task automatic check_abc();
    chk("abc_w0", obs_w[0], 32'h61626380);
    chk("abc_wp0", obs_wp[0], 32'h61626380);
    chk("abc_w16", obs_w[16], 32'h9092e200);
    chk("abc_w18", obs_w[18], 32'h000c0606);
    chk("abc_w19", obs_w[19], 32'h719c70ed);
    chk("abc_wp12", obs_wp[12], 32'h9092e200);
    chk("abc_wp15", obs_wp[15], 32'h719c70f5);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_blk_ready"}, 32'(blk_ready), 32'd1);
    chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
    chk({tag, "_w_j"}, w_j, 32'd0);
    chk({tag, "_wp_j"}, wp_j, 32'd0);
    chk({tag, "_round"}, 32'(round), 32'd0);
    chk({tag, "_last"}, 32'(last), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    blk_valid = 1'b0;
    w_ready = 1'b0;
    blk = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // "abc" block, full-rate consumer; 64 edges after accept means 65-cycle throughput
    load_abc();
    run_block(100, 1'b0, 64);
    check_abc();
    chk("abc_latency", last_cyc, 32'd64);

    // Reset wins over a simultaneous block offer
    rst = 1'b1;
    blk_valid = 1'b1;
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = blkw[i];
    @(posedge clk); #1;
    chk("rstvalid_w_valid", 32'(w_valid), 32'd0);
    chk("rstvalid_blk_ready", 32'(blk_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstvalid_accept", 32'(w_valid), 32'd1);
    chk("rstvalid_round", 32'(round), 32'd0);
    chk("rstvalid_w_j", w_j, 32'h61626380);
    blk_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // All-ones block
    for (int i = 0; i < 16; i++) blkw[i] = 32'hffffffff;
    run_block(100, 1'b0, 64);
    chk("ones_w16", obs_w[16], 32'hffffffff);
    for (int j = 0; j < 12; j++) chk("ones_wp", obs_wp[j], 32'h0);

    // Back-to-back with blk_valid held high and blk scrambled during RUN
    for (int i = 0; i < 16; i++) blkw[i] = $urandom();
    run_block(100, 1'b1, 64);
    for (int i = 0; i < 16; i++) blkw[i] = $urandom();
    run_block(100, 1'b0, 64);

    // Reset mid-block at round 30, then "abc" again
    for (int i = 0; i < 16; i++) blkw[i] = $urandom();
    run_block(100, 1'b0, 30);
    chk("mid_w_valid", 32'(w_valid), 32'd1);
    chk("mid_round", 32'(round), 32'd30);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    load_abc();
    run_block(100, 1'b0, 64);
    check_abc();
    chk("abc2_latency", last_cyc, 32'd64);

    // Random blocks under 30% consumer duty
    for (int b = 0; b < 200; b++) begin
      for (int i = 0; i < 16; i++) blkw[i] = $urandom();
      run_block(30, 1'b0, 64);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
